// File: rtl/ucsbece154a_mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields in, per-state controls out.
interface ucsbece154a_mc_controller_if;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       PCWrite_o;
  logic       Branch_o;
  logic       BranchZero_o;
  logic       IorD_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       RegDst_o;
  logic       MemToReg_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALUControl_o;
  logic [1:0] PCSrc_o;
  logic       ZeroExtImm_o;
  logic [3:0] state_o;
  logic       illegal_o;

  // Controller side.
  modport master (
    input  op_i, funct_i,
    output PCWrite_o, Branch_o, BranchZero_o, IorD_o, MemWrite_o, IRWrite_o, RegDst_o,
           MemToReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, PCSrc_o,
           ZeroExtImm_o, state_o, illegal_o
  );

  // Datapath side.
  modport slave (
    output op_i, funct_i,
    input  PCWrite_o, Branch_o, BranchZero_o, IorD_o, MemWrite_o, IRWrite_o, RegDst_o,
           MemToReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, PCSrc_o,
           ZeroExtImm_o, state_o, illegal_o
  );
endinterface

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle MIPS control FSM. State-only controls are registered alongside the
// state; ALU control, branch polarity and immediate extension decode op/funct.
module ucsbece154a_mc_controller (
  input logic                         clk,
  input logic                         reset,
  ucsbece154a_mc_controller_if.master bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10,
    StJump    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
  } moore_t;

  // Pure state-to-control table; unlisted fields stay 0.
  function automatic moore_t moore_out(input state_e s);
    moore_t m;
    m = '0;
    case (s)
      StFetch:   begin m.ir_write = 1'b1; m.alu_src_b = 2'b01; m.pc_write = 1'b1; end
      StDecode:  m.alu_src_b = 2'b11;
      StMemAdr:  begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      StMemRd:   m.iord = 1'b1;
      StMemWb:   begin m.mem_to_reg = 1'b1; m.reg_write = 1'b1; end
      StMemWr:   begin m.iord = 1'b1; m.mem_write = 1'b1; end
      StExecute: m.alu_src_a = 1'b1;
      StAluWb:   begin m.reg_dst = 1'b1; m.reg_write = 1'b1; end
      StBranch:  begin m.alu_src_a = 1'b1; m.pc_src = 2'b01; m.branch = 1'b1; end
      StImmEx:   begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      StImmWb:   m.reg_write = 1'b1;
      StJump:    begin m.pc_src = 2'b10; m.pc_write = 1'b1; end
      default:   m = '0;
    endcase
    return m;
  endfunction

  state_e state_q, state_d;
  moore_t moore_q, moore;
  logic   op_legal;
  logic [2:0] alu_control;
  logic   branch_zero;
  logic   zero_ext_imm;

  assign op_legal = (bus.op_i inside {OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAndi,
                                      OpOri, OpJ});

  // Next-state selection; DECODE dispatches on opcode.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        case (bus.op_i)
          OpLw, OpSw:              state_d = StMemAdr;
          OpRtype:                 state_d = StExecute;
          OpBeq, OpBne:            state_d = StBranch;
          OpAddi, OpAndi, OpOri:   state_d = StImmEx;
          OpJ:                     state_d = StJump;
          default:                 state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StImmEx:   state_d = StImmWb;
      default:   state_d = StFetch;
    endcase
  end

  // State register with its controls registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      moore_q <= moore_out(StFetch);
    end else begin
      state_q <= state_d;
      moore_q <= moore_out(state_d);
    end
  end

  // Reset shows FETCH mux settings immediately but suppresses every write enable.
  always_comb begin
    moore = moore_q;
    if (reset) begin
      moore           = moore_out(StFetch);
      moore.pc_write  = 1'b0;
      moore.ir_write  = 1'b0;
      moore.reg_write = 1'b0;
      moore.mem_write = 1'b0;
      moore.branch    = 1'b0;
    end
  end

  // Instruction-dependent controls.
  always_comb begin
    alu_control  = AluAdd;
    branch_zero  = 1'b0;
    zero_ext_imm = 1'b0;
    if (!reset) begin
      case (state_q)
        StExecute: begin
          case (bus.funct_i)
            FnSub:   alu_control = AluSub;
            FnAnd:   alu_control = AluAnd;
            FnOr:    alu_control = AluOr;
            FnSlt:   alu_control = AluSlt;
            default: alu_control = AluAdd;
          endcase
        end
        StBranch: begin
          alu_control = AluSub;
          branch_zero = (bus.op_i == OpBeq);
        end
        StImmEx: begin
          case (bus.op_i)
            OpAndi:  begin alu_control = AluAnd; zero_ext_imm = 1'b1; end
            OpOri:   begin alu_control = AluOr;  zero_ext_imm = 1'b1; end
            default: alu_control = AluAdd;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite_o    = moore.pc_write;
  assign bus.Branch_o     = moore.branch;
  assign bus.BranchZero_o = branch_zero;
  assign bus.IorD_o       = moore.iord;
  assign bus.MemWrite_o   = moore.mem_write;
  assign bus.IRWrite_o    = moore.ir_write;
  assign bus.RegDst_o     = moore.reg_dst;
  assign bus.MemToReg_o   = moore.mem_to_reg;
  assign bus.RegWrite_o   = moore.reg_write;
  assign bus.ALUSrcA_o    = moore.alu_src_a;
  assign bus.ALUSrcB_o    = moore.alu_src_b;
  assign bus.ALUControl_o = alu_control;
  assign bus.PCSrc_o      = moore.pc_src;
  assign bus.ZeroExtImm_o = zero_ext_imm;
  assign bus.state_o      = reset ? 4'd0 : state_q;
  assign bus.illegal_o    = !reset && (state_q == StDecode) && !op_legal;

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Randomized bench for the multicycle controller: an instruction-level model
// (phase list per opcode class) predicts every cycle's outputs.
module tb_ucsbece154a_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;

  always #5 clk = ~clk;

  ucsbece154a_mc_controller_if bus_if ();
  assign bus_if.op_i    = op;
  assign bus_if.funct_i = funct;

  ucsbece154a_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       illegal;
    logic       pcw;
    logic       br;
    logic       bz;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       memtoreg;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic       zext;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  // Instruction-level model: current phase plus remaining phases of this instruction.
  int exp_state = 0;
  int pending[$];

  function automatic void load_phases(input logic [5:0] o);
    pending.delete();
    pending.push_back(1);
    case (o)
      6'b100011: begin pending.push_back(2); pending.push_back(3); pending.push_back(4); end
      6'b101011: begin pending.push_back(2); pending.push_back(5); end
      6'b000000: begin pending.push_back(6); pending.push_back(7); end
      6'b000100, 6'b000101: pending.push_back(8);
      6'b001000, 6'b001100, 6'b001101: begin pending.push_back(9); pending.push_back(10); end
      6'b000010: pending.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic exp_t exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                   input logic rst);
    exp_t e;
    e = '0;
    e.alu = 3'b010;
    if (rst) begin
      e.srcb = 2'b01;
      return e;
    end
    e.state = st[3:0];
    case (st)
      0: begin e.irw = 1; e.srcb = 2'b01; e.pcw = 1; end
      1: begin
        e.srcb = 2'b11;
        e.illegal = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b000010});
      end
      2: begin e.srca = 1; e.srcb = 2'b10; end
      3: e.iord = 1;
      4: begin e.memtoreg = 1; e.regw = 1; end
      5: begin e.iord = 1; e.memw = 1; end
      6: begin
        e.srca = 1;
        case (f)
          6'b100010: e.alu = 3'b110;
          6'b100100: e.alu = 3'b000;
          6'b100101: e.alu = 3'b001;
          6'b101010: e.alu = 3'b111;
          default:   e.alu = 3'b010;
        endcase
      end
      7: begin e.regdst = 1; e.regw = 1; end
      8: begin e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.br = 1; e.bz = (o == 6'b000100); end
      9: begin
        e.srca = 1;
        e.srcb = 2'b10;
        if (o == 6'b001100) begin e.alu = 3'b000; e.zext = 1; end
        else if (o == 6'b001101) begin e.alu = 3'b001; e.zext = 1; end
      end
      10: e.regw = 1;
      11: begin e.pcsrc = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Advance the model on each active edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_state = 0;
      pending.delete();
    end else if (exp_state == 0) begin
      load_phases(op);
      exp_state = pending.pop_front();
    end else if (pending.size() == 0) begin
      exp_state = 0;
    end else begin
      exp_state = pending.pop_front();
    end
  end

  // Directed-window captures used to pin the model with literal values.
  int         trace[$];
  logic [2:0] exec_alu[$];
  logic       branch_bz[$];
  logic [3:0] immex_seen[$];
  exp_t       first_fetch;
  bit         have_first_fetch = 0;

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    exp_t e, a;
    e = exp_out(exp_state, op, funct, reset);
    a.state    = bus_if.state_o;
    a.illegal  = bus_if.illegal_o;
    a.pcw      = bus_if.PCWrite_o;
    a.br       = bus_if.Branch_o;
    a.bz       = bus_if.BranchZero_o;
    a.iord     = bus_if.IorD_o;
    a.memw     = bus_if.MemWrite_o;
    a.irw      = bus_if.IRWrite_o;
    a.regdst   = bus_if.RegDst_o;
    a.memtoreg = bus_if.MemToReg_o;
    a.regw     = bus_if.RegWrite_o;
    a.srca     = bus_if.ALUSrcA_o;
    a.srcb     = bus_if.ALUSrcB_o;
    a.alu      = bus_if.ALUControl_o;
    a.pcsrc    = bus_if.PCSrc_o;
    a.zext     = bus_if.ZeroExtImm_o;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL cycle t=%0t rst=%0b op=%b funct=%b model_state=%0d: got %h want %h",
               $time, reset, op, funct, exp_state, a, e);
    end
    if (!reset && trace.size() < 32) begin
      trace.push_back(int'(a.state));
      if (!have_first_fetch) begin first_fetch = a; have_first_fetch = 1; end
      if (a.state == 4'd6) exec_alu.push_back(a.alu);
      if (a.state == 4'd8) branch_bz.push_back(a.bz);
      if (a.state == 4'd9) immex_seen.push_back({a.alu, a.zext});
    end
  end

  localparam int NDir = 9;
  logic [5:0] dir_op[NDir] = '{6'b100011, 6'b000000, 6'b000000, 6'b000101, 6'b000100,
                               6'b001101, 6'b000010, 6'b111111, 6'b100011};
  logic [5:0] dir_fn[NDir] = '{6'd0, 6'b101010, 6'b100010, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
  bit         dir_kill[NDir] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [5:0] legal_ops[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b000000};
  logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  int         exp_trace[32] = '{0, 1, 2, 3, 4, 0, 1, 6, 7, 0, 1, 6, 7, 0, 1, 8, 0, 1, 8,
                                0, 1, 9, 10, 0, 1, 11, 0, 1, 0, 1, 2, 0};

  initial begin
    int  idx;
    bit  kill_pending;
    bit  ok;
    idx = 0;
    kill_pending = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      if (reset) reset = 1'b0;
      else if (kill_pending && exp_state == 3) begin reset = 1'b1; kill_pending = 0; end
      else if (idx >= NDir && $urandom_range(0, 39) == 0) reset = 1'b1;
      if (!reset && exp_state == 0) begin
        if (idx < NDir) begin
          op = dir_op[idx];
          funct = dir_fn[idx];
          kill_pending = dir_kill[idx];
          idx++;
        end else begin
          op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                          : legal_ops[$urandom_range(0, 9)];
          funct = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_fn[$urandom_range(0, 4)];
        end
      end
      @(posedge clk);
      #1;
    end

    // Literal pins for the directed opening sequence.
    ok = (trace.size() == 32);
    for (int i = 0; i < 32 && ok; i++) if (trace[i] != exp_trace[i]) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL state_trace: got %p want %p", trace, exp_trace);
    end
    vectors++;
    if (!have_first_fetch || !first_fetch.pcw || !first_fetch.irw || first_fetch.srcb != 2'b01
        || first_fetch.state != 4'd0) begin
      miscompares++;
      $display("FAIL first_fetch: got %h want pcw=1 irw=1 srcb=01 state=0", first_fetch);
    end
    vectors++;
    if (exec_alu.size() != 2 || exec_alu[0] != 3'b111 || exec_alu[1] != 3'b110) begin
      miscompares++;
      $display("FAIL exec_alu: got %p want 111,110", exec_alu);
    end
    vectors++;
    if (branch_bz.size() != 2 || branch_bz[0] != 1'b0 || branch_bz[1] != 1'b1) begin
      miscompares++;
      $display("FAIL branch_zero: got %p want 0,1", branch_bz);
    end
    vectors++;
    if (immex_seen.size() != 1 || immex_seen[0] != 4'b0011) begin
      miscompares++;
      $display("FAIL ori_immex: got %p want alu=001 zext=1", immex_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_mc_controller.md
Name: ucsbece154a_mc_controller

Overview:
- Multicycle control FSM for the MIPS core: replaces the single-cycle combinational controller so one shared memory and one ALU are reused across cycles.
- Sits beside the multicycle datapath, takes op/funct from the instruction register, and drives per-state enables and muxes.
- Supports R-type (add, sub, and, or, slt), lw, sw, beq, bne, addi, andi, ori and j.

Parameters:
- none (ISA subset and encodings fixed)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; forces FSM to FETCH
- op_i  input  6  instr[31:26] from instruction register (stable from DECODE onward)
- funct_i  input  6  instr[5:0] from instruction register
- PCWrite_o  output  1  unconditional PC load
- Branch_o  output  1  conditional PC load qualifier
- BranchZero_o  output  1  1: take branch when Zero=1 (beq); 0: when Zero=0 (bne)
- IorD_o  output  1  memory address select, 0=PC, 1=ALUOut
- MemWrite_o  output  1  data memory write enable
- IRWrite_o  output  1  instruction register load
- RegDst_o  output  1  write register select, 1=rd, 0=rt
- MemToReg_o  output  1  writeback select, 1=Data register, 0=ALUOut
- RegWrite_o  output  1  register file write enable
- ALUSrcA_o  output  1  0=PC, 1=register A
- ALUSrcB_o  output  2  00=B, 01=constant 4, 10=immediate, 11=immediate<<2
- ALUControl_o  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc_o  output  2  00=ALU result, 01=ALUOut, 10=jump target
- ZeroExtImm_o  output  1  zero-extend rather than sign-extend immediate
- state_o  output  4  current state encoding, for verification
- illegal_o  output  1  one-cycle pulse in DECODE on unsupported opcode

Behaviour:
- Moore outputs from state, except ALUControl_o, BranchZero_o and ZeroExtImm_o, which also decode op_i/funct_i. Every output not listed for a state is 0; ALUControl defaults to 010.
- States and encodings:
  - FETCH 0: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next by op:
    - lw/sw (100011/101011) -> MEMADR
    - R (000000) -> EXECUTE
    - beq/bne (000100/000101) -> BRANCH
    - addi/andi/ori (001000/001100/001101) -> IMMEX
    - j (000010) -> JUMP
    - any other op -> FETCH with illegal_o=1
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, add. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD 3: IorD=1. Next: MEMWB.
  - MEMWB 4: RegDst=0, MemToReg=1, RegWrite=1. Next: FETCH.
  - MEMWR 5: IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE 6: ALUSrcA=1, ALUSrcB=00. ALUControl by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010. Next: ALUWB.
  - ALUWB 7: RegDst=1, MemToReg=0, RegWrite=1. Next: FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, 110, PCSrc=01, Branch=1, BranchZero=(op==000100). Next: FETCH.
  - IMMEX 9: ALUSrcA=1, ALUSrcB=10. ALUControl: addi 010, andi 000, ori 001. ZeroExtImm=1 for andi/ori. Next: IMMWB.
  - IMMWB 10: RegDst=0, MemToReg=0, RegWrite=1. Next: FETCH.
  - JUMP 11: PCSrc=10, PCWrite=1. Next: FETCH.
  - Codes 12-15 unreachable; if entered, all enables 0 and next is FETCH.
- Cycle counts including FETCH: lw 5; sw, R, imm 4; beq, bne, j 3; illegal 2.
- Datapath PC enable is PCWrite | (Branch & (Zero == BranchZero)). Controller never asserts PCWrite and Branch together.
- Reset:
  - While reset=1: state_o=0 and outputs show FETCH mux values, but PCWrite, IRWrite, RegWrite, MemWrite and Branch are forced 0; illegal_o=0.
  - First non-reset edge leaves FETCH for DECODE.
  - Reset mid-instruction abandons it with no further writes.
- At most one of IRWrite, MemWrite, RegWrite is asserted in any cycle.

Test Plan:
- Hold reset 3 cycles, then release -> enables 0 during reset; after release, state sequence 0,1 with FETCH outputs PCWrite=1, IRWrite=1, ALUSrcB=01.
- op=100011 (lw) -> states 0,1,2,3,4,0; MEMRD IorD=1; MEMWB RegWrite=1, MemToReg=1, RegDst=0; MemWrite never 1.
- R-type with funct=101010 then funct=100010 -> EXECUTE ALUControl=111 then 110; ALUWB RegWrite=1, RegDst=1; each takes 4 cycles.
- op=000101 (bne) -> states 0,1,8,0; BRANCH Branch=1, BranchZero=0, ALUControl=110, PCSrc=01. Repeat with op=000100 -> BranchZero=1.
- op=001101 (ori) -> IMMEX ALUControl=001, ZeroExtImm=1; IMMWB RegWrite=1, RegDst=0. Then op=000010 (j) -> JUMP PCSrc=10, PCWrite=1, 3 cycles.
- op=111111 -> illegal_o=1 for one cycle in DECODE, next state FETCH, no writes. Separately, assert reset during MEMRD of lw -> MEMWB never reached, RegWrite stays 0.
